// File: rtl/sync_fifo_stream_reader.sv
// Read-side adapter for sync_fifo: drains the 1-cycle-latency read port into a
// 2-entry skid buffer and presents it as a valid/ready stream.
module sync_fifo_stream_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [CNT_WIDTH-1:0]  r_words;

    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_slot0;
    logic [1:0]            w_occ_next;
    logic [DATA_WIDTH-1:0] w_buf0_next;
    logic [DATA_WIDTH-1:0] w_buf1_next;

    assign m_valid   = (r_occ != ST_EMPTY);
    assign m_data    = r_buf0;
    assign words_out = r_words;
    assign w_pop     = m_valid & m_ready;

    // Occupancy after this cycle's capture and pop; a new read may only be
    // issued if its word is guaranteed a free slot when it lands.
    assign w_level    = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign fifo_rd_en = rst & ~flush & ~fifo_empty & (w_level < 3'd2);

    always_comb begin
        w_occ_next = r_occ;
        case (r_occ)
            ST_EMPTY: begin
                if (r_inflight) w_occ_next = ST_ONE;
            end
            ST_ONE: begin
                if (r_inflight && !w_pop)      w_occ_next = ST_TWO;
                else if (!r_inflight && w_pop) w_occ_next = ST_EMPTY;
            end
            ST_TWO: begin
                if (w_pop && !r_inflight) w_occ_next = ST_ONE;
            end
            default: w_occ_next = ST_EMPTY;
        endcase
    end

    // Captured word lands in the first slot that is free after the pop shift.
    assign w_slot0 = (r_occ == ST_EMPTY) || ((r_occ == ST_ONE) && w_pop);

    always_comb begin
        w_buf0_next = r_buf0;
        w_buf1_next = r_buf1;
        if (w_pop) w_buf0_next = r_buf1;
        if (r_inflight) begin
            if (w_slot0) w_buf0_next = fifo_dout;
            else         w_buf1_next = fifo_dout;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            r_occ      <= ST_EMPTY;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_words    <= '0;
        end else if (flush) begin
            r_occ      <= ST_EMPTY;
            r_inflight <= 1'b0;
        end else begin
            r_occ      <= w_occ_next;
            r_inflight <= fifo_rd_en;
            r_buf0     <= w_buf0_next;
            r_buf1     <= w_buf1_next;
            if (w_pop) r_words <= r_words + 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!rst)
        !((r_occ == ST_TWO) && r_inflight && !w_pop));

    a_no_read_empty: assert property (@(posedge clock)
        !(fifo_rd_en && fifo_empty));

    a_occ_legal: assert property (@(posedge clock) disable iff (!rst)
        r_occ != 2'd3);

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Directed and randomised checks of sync_fifo_stream_reader against a
// behavioural FIFO with 1-cycle registered read latency.
module tb_sync_fifo_stream_reader;

    logic        clock = 1'b0;
    logic        rst;
    logic [63:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic        flush;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  words_out;

    logic        wr_en;
    logic [63:0] wr_data;
    logic        fifo_clr;
    logic        sb_on = 1'b0;

    logic [63:0] fq[$];
    logic [63:0] exp_q[$];

    int tests = 0;
    int fails = 0;

    sync_fifo_stream_reader #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut (
        .clock     (clock),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .flush     (flush),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .words_out (words_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (fifo_clr) begin
            fq.delete();
            fifo_dout  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(negedge clock) begin
        if (fifo_empty) begin
            tests++;
            if (fifo_rd_en) begin
                fails++;
                $display("FAIL rd_when_empty: fifo_rd_en=%0b required 0", fifo_rd_en);
            end
        end
        if (sb_on && m_valid && m_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got beat %h, required none", m_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    fails++;
                    $display("FAIL sb_order: got %h required %h", m_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] wdata;
        logic        rdy;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic        exp_rd;
    } vec_t;

    vec_t vt[9];

    initial begin
        int rd_cnt;
        int written;
        int beats;
        logic seen;

        vt[0] = '{1'b1, 64'h1, 1'b1, 1'b0, 64'h0, 1'b0};
        vt[1] = '{1'b1, 64'h2, 1'b1, 1'b0, 64'h0, 1'b1};
        vt[2] = '{1'b1, 64'h3, 1'b1, 1'b0, 64'h0, 1'b1};
        vt[3] = '{1'b1, 64'h4, 1'b1, 1'b1, 64'h1, 1'b1};
        vt[4] = '{1'b1, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1};
        vt[5] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h3, 1'b1};
        vt[6] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h4, 1'b0};
        vt[7] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h5, 1'b0};
        vt[8] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0};

        rst = 1'b0; flush = 1'b0; m_ready = 1'b0;
        wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b0;
        next_cycle();

        // Reset held with the FIFO being loaded
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 64'hA0 + 64'(i);
            @(negedge clock);
            chk("rst_valid", {63'b0, m_valid}, 64'h0);
            chk("rst_rd_en", {63'b0, fifo_rd_en}, 64'h0);
            chk("rst_words", {60'b0, words_out}, 64'h0);
            chk("rst_data", m_data, 64'h0);
            next_cycle();
        end
        wr_en = 1'b0; fifo_clr = 1'b1;
        next_cycle();
        fifo_clr = 1'b0; rst = 1'b1;

        // Full-throughput stream, cycle by cycle
        for (int i = 0; i < 9; i++) begin
            wr_en = vt[i].wr; wr_data = vt[i].wdata; m_ready = vt[i].rdy;
            @(negedge clock);
            chk($sformatf("vec%0d_valid", i), {63'b0, m_valid}, {63'b0, vt[i].exp_valid});
            chk($sformatf("vec%0d_rd_en", i), {63'b0, fifo_rd_en}, {63'b0, vt[i].exp_rd});
            if (vt[i].exp_valid) chk($sformatf("vec%0d_data", i), m_data, vt[i].exp_data);
            next_cycle();
        end
        wr_en = 1'b0;
        chk("stream_words", {60'b0, words_out}, 64'd5);

        // Backpressure: 6 words, consumer stalled
        m_ready = 1'b0; rd_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            wr_en = (c < 6); wr_data = 64'(c + 1);
            @(negedge clock);
            if (fifo_rd_en) rd_cnt++;
            if (c >= 6) begin
                chk("stall_valid", {63'b0, m_valid}, 64'h1);
                chk("stall_data", m_data, 64'h1);
            end
            next_cycle();
        end
        wr_en = 1'b0;
        chk("stall_reads", 64'(rd_cnt), 64'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("release%0d_valid", i), {63'b0, m_valid}, 64'h1);
            chk($sformatf("release%0d_data", i), m_data, 64'(i + 1));
            next_cycle();
        end
        @(negedge clock);
        chk("release_end_valid", {63'b0, m_valid}, 64'h0);
        next_cycle();
        chk("release_words", {60'b0, words_out}, 64'd11);

        // Random consumer, 200 random words through the scoreboard
        sb_on = 1'b1; written = 0;
        for (int cy = 0; cy < 4000 && !(written == 200 && exp_q.size() == 0); cy++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (written < 200 && $urandom_range(0, 9) < 7) begin
                wr_en = 1'b1; wr_data = {$urandom, $urandom};
                exp_q.push_back(wr_data);
                written++;
            end else begin
                wr_en = 1'b0;
            end
            next_cycle();
        end
        wr_en = 1'b0;
        chk("random_written", 64'(written), 64'd200);
        chk("random_drained", 64'(exp_q.size()), 64'd0);
        sb_on = 1'b0; m_ready = 1'b1;
        repeat (3) next_cycle();
        @(negedge clock);
        chk("random_idle_valid", {63'b0, m_valid}, 64'h0);
        chk("random_words", {60'b0, words_out}, 64'd3);
        next_cycle();

        // Flush with one word buffered and one read in flight
        m_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            wr_en = (c < 5); wr_data = 64'h41 + 64'(c);
            next_cycle();
        end
        wr_en = 1'b0; m_ready = 1'b1;
        @(negedge clock);
        chk("flushA_data", m_data, 64'h41);
        chk("flushA_rd_en", {63'b0, fifo_rd_en}, 64'h1);
        next_cycle();
        m_ready = 1'b0; flush = 1'b1;
        @(negedge clock);
        chk("flushB_rd_en", {63'b0, fifo_rd_en}, 64'h0);
        chk("flushB_data", m_data, 64'h42);
        next_cycle();
        flush = 1'b0; m_ready = 1'b1;
        @(negedge clock);
        chk("flushC_valid", {63'b0, m_valid}, 64'h0);
        chk("flushC_words", {60'b0, words_out}, 64'd4);
        chk("flushC_rd_en", {63'b0, fifo_rd_en}, 64'h1);
        seen = 1'b0;
        for (int cy = 0; cy < 6 && !seen; cy++) begin
            next_cycle();
            @(negedge clock);
            seen = m_valid;
        end
        chk("flush_resume_seen", {63'b0, seen}, 64'h1);
        chk("flush_next_beat", m_data, 64'h44);
        next_cycle();
        @(negedge clock);
        chk("flush_last_beat", m_data, 64'h45);
        next_cycle();
        @(negedge clock);
        chk("flush_end_valid", {63'b0, m_valid}, 64'h0);
        chk("flush_words", {60'b0, words_out}, 64'd6);
        next_cycle();

        // Reset mid-operation, then counter wrap over 17 beats
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            wr_en = (c < 3); wr_data = 64'hC0 + 64'(c);
            next_cycle();
        end
        wr_en = 1'b0; rst = 1'b0; fifo_clr = 1'b1;
        next_cycle();
        @(negedge clock);
        chk("midrst_valid", {63'b0, m_valid}, 64'h0);
        chk("midrst_words", {60'b0, words_out}, 64'h0);
        chk("midrst_rd_en", {63'b0, fifo_rd_en}, 64'h0);
        next_cycle();
        rst = 1'b1; fifo_clr = 1'b0; m_ready = 1'b1;
        beats = 0;
        for (int cy = 0; cy < 60; cy++) begin
            wr_en = (cy < 17); wr_data = 64'h100 + 64'(cy);
            @(negedge clock);
            if (m_valid) begin
                chk("wrap_data", m_data, 64'h100 + 64'(beats));
                beats++;
            end
            next_cycle();
        end
        wr_en = 1'b0;
        chk("wrap_beats", 64'(beats), 64'd17);
        chk("wrap_words", {60'b0, words_out}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
